// File: rtl/fp_align_stage_pkg.sv
// fp_align_stage_pkg: shared float field widths, fp_t, align FSM states and eff_exp helper
package fp_align_stage_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int GRS_W = 3;
  localparam int SMANT_W = MANT_W + GRS_W;
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_t;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} align_state_t;
  function automatic logic [EXP_W-1:0] eff_exp(fp_t x);
    return (x.exp == '0) ? EXP_W'(1) : x.exp;
  endfunction
endpackage

// File: rtl/fp_sticky_shifter.sv
// fp_sticky_shifter: combinational right shift of din by amt, ORing every shifted-out bit into dout[0]
module fp_sticky_shifter
  import fp_align_stage_pkg::*;
(
  input  logic [SMANT_W-1:0] din,
  input  logic [4:0]         amt,
  output logic [SMANT_W-1:0] dout
);
  logic [SMANT_W-1:0] lost_mask;
  assign lost_mask = (SMANT_W'(1) << amt) - SMANT_W'(1);
  assign dout = (din >> amt) | {{(SMANT_W-1){1'b0}}, |(din & lost_mask)};
endmodule

// File: rtl/fp_align_stage.sv
// fp_align_stage: aligns small significand to big exponent (G/R/S) iteratively; ports clk/rst_n, in_valid/in_ready/big_number/small_number, out_valid/out_ready/out_sign_*/out_exp/out_*_mant, out_special with FP_ALIGN_SPECIAL_EN
module fp_align_stage
  import fp_align_stage_pkg::*;
#(
  parameter int SHIFT_PER_CYCLE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  fp_t                big_number,
  input  fp_t                small_number,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign_big,
  output logic               out_sign_small,
  output logic [EXP_W-1:0]   out_exp,
  output logic [MANT_W-1:0]  out_big_mant,
  output logic [SMANT_W-1:0] out_small_mant
`ifdef FP_ALIGN_SPECIAL_EN
  ,
  output logic               out_special
`endif
);
  align_state_t state, state_nx;
  logic [EXP_W-1:0] eb, es, diff, remaining;
  logic hb, hs, special_in, load_done;
  logic [4:0] step;
  logic [SMANT_W-1:0] shifted;
  assign eb = eff_exp(big_number);
  assign es = eff_exp(small_number);
  assign diff = eb - es;
  assign hb = |big_number.exp;
  assign hs = |small_number.exp;
`ifdef FP_ALIGN_SPECIAL_EN
  assign special_in = (&big_number.exp) | (&small_number.exp);
`else
  assign special_in = 1'b0;
`endif
  assign load_done = special_in || diff == '0 || diff >= EXP_W'(SMANT_W);
  assign step = (remaining < EXP_W'(SHIFT_PER_CYCLE)) ? remaining[4:0] : 5'(SHIFT_PER_CYCLE);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  fp_sticky_shifter u_shift (
    .din  (out_small_mant),
    .amt  (step),
    .dout (shifted)
  );
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (in_valid ? (load_done ? DONE : SHIFT) : IDLE)
             : (state == SHIFT) ? ((remaining == {3'b0, step}) ? DONE : SHIFT)
             : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sign_big   <= 1'b0;
      out_sign_small <= 1'b0;
      out_exp        <= '0;
      out_big_mant   <= '0;
      out_small_mant <= '0;
      remaining      <= '0;
    end else if (state == IDLE && in_valid) begin
      out_sign_big   <= big_number.sign;
      out_sign_small <= small_number.sign;
      out_exp        <= eb;
      out_big_mant   <= {hb, big_number.frac};
      remaining      <= diff;
      out_small_mant <= (!special_in && diff >= EXP_W'(SMANT_W))
                        ? {{(SMANT_W-1){1'b0}}, hs | (|small_number.frac)}
                        : {hs, small_number.frac, {GRS_W{1'b0}}};
    end else if (state == SHIFT) begin
      out_small_mant <= shifted;
      remaining      <= remaining - {3'b0, step};
    end
  end
`ifdef FP_ALIGN_SPECIAL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_special <= 1'b0;
    else if (state == IDLE && in_valid) out_special <= special_in;
  end
`endif
endmodule

// File: tb/tb_fp_align_stage.sv
// tb_fp_align_stage: randomized scoreboard bench for fp_align_stage against an arithmetic alignment model
module tb_fp_align_stage;
  import fp_align_stage_pkg::*;
  localparam int SPC = 4;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  fp_t big_number = '0, small_number = '0;
  logic in_ready, out_valid, out_sign_big, out_sign_small;
  logic [7:0] out_exp;
  logic [23:0] out_big_mant;
  logic [26:0] out_small_mant;
`ifdef FP_ALIGN_SPECIAL_EN
  logic out_special;
`endif
  fp_align_stage #(.SHIFT_PER_CYCLE(SPC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .big_number(big_number), .small_number(small_number),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign_big(out_sign_big), .out_sign_small(out_sign_small),
    .out_exp(out_exp), .out_big_mant(out_big_mant), .out_small_mant(out_small_mant)
`ifdef FP_ALIGN_SPECIAL_EN
    , .out_special(out_special)
`endif
  );
  typedef struct {
    logic sb, ss, sp;
    logic [7:0] e;
    logic [23:0] bm;
    logic [26:0] sm;
    int lat, acc;
  } exp_t;
  exp_t sb_q[$];
  int n_checks = 0, n_fail = 0, cyc = 0;
  bit hold_low = 0, rand_bp = 0, timed = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #2;
    out_ready = hold_low ? 1'b0 : (rand_bp ? 1'($urandom_range(0, 1)) : 1'b1);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask
  function automatic exp_t model(fp_t b, fp_t s);
    exp_t r;
    int eb, es, d;
    longint unsigned m, q;
    eb = (b.exp == 0) ? 1 : int'(b.exp);
    es = (s.exp == 0) ? 1 : int'(s.exp);
    d = eb - es;
    r.sb = b.sign;
    r.ss = s.sign;
    r.e = 8'(eb);
    r.bm = {b.exp != 0, b.frac};
    m = 64'({s.exp != 0, s.frac}) * 8;
`ifdef FP_ALIGN_SPECIAL_EN
    r.sp = (b.exp == 8'hFF) || (s.exp == 8'hFF);
`else
    r.sp = 1'b0;
`endif
    r.acc = 0;
    if (r.sp) begin
      r.sm = 27'(m);
      r.lat = 1;
    end else begin
      q = (d >= 64) ? 64'd0 : (m >> d);
      r.sm = 27'(q | 64'(((d >= 64) ? 64'd0 : (q << d)) != m));
      r.lat = (d >= 27) ? 1 : 1 + (d + SPC - 1) / SPC;
    end
    return r;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (!out_valid) timed = 0;
    else if (rst_n) begin
      if (sb_q.size() == 0) check("unexpected_out_valid", 32'(out_valid), 32'd0);
      else begin
        if (!timed) begin
          check("latency", 32'(cyc - sb_q[0].acc), 32'(sb_q[0].lat));
          timed = 1;
        end
        if (out_ready) begin
          e = sb_q.pop_front();
          timed = 0;
          check("sign_big", 32'(out_sign_big), 32'(e.sb));
          check("sign_small", 32'(out_sign_small), 32'(e.ss));
          check("out_exp", 32'(out_exp), 32'(e.e));
          check("big_mant", 32'(out_big_mant), 32'(e.bm));
          check("small_mant", 32'(out_small_mant), 32'(e.sm));
`ifdef FP_ALIGN_SPECIAL_EN
          check("special", 32'(out_special), 32'(e.sp));
`endif
        end
      end
    end
  end
  task automatic send(input fp_t b, input fp_t s);
    exp_t e;
    int w;
    big_number = b;
    small_number = s;
    in_valid = 1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 300) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 0;
      return;
    end
    e = model(b, s);
    e.acc = cyc;
    sb_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 500) begin
      w++;
      @(posedge clk);
    end
    if (sb_q.size() != 0) check("drain_timeout", 32'(sb_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask
  task automatic rand_pair(output fp_t b, output fp_t s);
    fp_t a, c;
    a = fp_t'($urandom);
    c = fp_t'($urandom);
    if ($urandom_range(0, 3) != 0) c.exp = a.exp - 8'($urandom_range(0, 32));
    if ($urandom_range(0, 7) == 0) c.exp = 8'h00;
    if ({c.exp, c.frac} > {a.exp, a.frac}) begin
      b = c;
      s = a;
    end else begin
      b = a;
      s = c;
    end
  endtask
  initial begin
    exp_t e;
    fp_t b, s;
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    exp_t e;
    fp_t b, s;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_exp", 32'(out_exp), 32'd0);
    check("rst_big_mant", 32'(out_big_mant), 32'd0);
    check("rst_small_mant", 32'(out_small_mant), 32'd0);
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    send(32'h3F800000, 32'h3F000000);
    drain();
    send(32'h3F800000, 32'h33800001);
    drain();
    send(32'h3F800000, 32'h00000001);
    drain();
    hold_low = 1;
    e = model(32'h40490FDB, 32'h40490FDB);
    send(32'h40490FDB, 32'h40490FDB);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_small_mant", 32'(out_small_mant), 32'(e.sm));
      check("bp_big_mant", 32'(out_big_mant), 32'(e.bm));
    end
    @(posedge clk);
    #1 hold_low = 0;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check("bp_idle_out_valid", 32'(out_valid), 32'd0);
    drain();
    send(32'h3F800000, 32'h33800001);
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_exp", 32'(out_exp), 32'd0);
    check("abort_big_mant", 32'(out_big_mant), 32'd0);
    check("abort_small_mant", 32'(out_small_mant), 32'd0);
    sb_q.delete();
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    send(32'h3F800000, 32'h3F000000);
    drain();
`ifdef FP_ALIGN_SPECIAL_EN
    send(32'h7F800000, 32'h3F800000);
    drain();
`endif
    rand_bp = 1;
    for (int i = 0; i < 150; i++) begin
      rand_pair(b, s);
      send(b, s);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    drain();
    rand_bp = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
